// File: rtl/spi_command_sequencer_pkg.sv
// Shared types and elaboration-time helpers for the SPI command sequencer.
package spi_seq_pkg;

  localparam int SEQ_MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    RESP
  } seq_state_t;

  function automatic int seq_len(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

  // Reads leave the data field undriven so the slave can return bits there.
  function automatic logic [SEQ_MAX_WIDTH-1:0] seq_mask(input int len, input int data_w,
                                                        input logic rw);
    logic [SEQ_MAX_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < SEQ_MAX_WIDTH; i++) begin
      m[i] = (i < len) && (!rw || (i >= data_w));
    end
    return m;
  endfunction

endpackage

// File: rtl/spi_command_sequencer_if.sv
// Command and read-response channels between a register client and the sequencer.
interface spi_command_sequencer_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_BITS  = 8,
  parameter int GAP_WIDTH  = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_rw;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_BITS-1:0]  cmd_wdata;
  logic [GAP_WIDTH-1:0]  gap_cycles;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_BITS-1:0]  rsp_rdata;

  modport master (
    output cmd_valid, cmd_rw, cmd_addr, cmd_wdata, gap_cycles, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata, gap_cycles, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/spi_command_sequencer.sv
// Formats one register command into a single-cycle SPI request, then waits max(gap,1) cycles.
// Write: cmd_ready returns G+2 cycles after accept; read: rsp_valid held until rsp_ready.
module spi_command_sequencer
  import spi_seq_pkg::*;
#(
  parameter int DATA_WIDTH            = 32,
  parameter int TRANSACTION_LEN_WIDTH = 8,
  parameter int ADDR_WIDTH            = 15,
  parameter int DATA_BITS             = 8,
  parameter int GAP_WIDTH             = 16
) (
  input  logic                             fabric_clk,
  input  logic                             reset,
  spi_command_sequencer_if.slave           bus,
  output logic [TRANSACTION_LEN_WIDTH-1:0] transaction_length,
  output logic [DATA_WIDTH-1:0]            transaction_data,
  output logic [DATA_WIDTH-1:0]            transaction_rw_mask,
  input  logic [DATA_WIDTH-1:0]            transaction_read_data,
  output logic                             busy
);

  localparam int LEN = seq_len(ADDR_WIDTH, DATA_BITS);

  if (LEN > DATA_WIDTH || LEN >= 2 ** TRANSACTION_LEN_WIDTH || DATA_WIDTH > SEQ_MAX_WIDTH) begin : g_bad_cfg
    $error("spi_command_sequencer: instruction word does not fit the SPI core buses");
  end

  localparam logic [TRANSACTION_LEN_WIDTH-1:0] LEN_VAL = TRANSACTION_LEN_WIDTH'(LEN);
  localparam logic [SEQ_MAX_WIDTH-1:0] WMASK_FULL = seq_mask(LEN, DATA_BITS, 1'b0);
  localparam logic [SEQ_MAX_WIDTH-1:0] RMASK_FULL = seq_mask(LEN, DATA_BITS, 1'b1);
  localparam logic [DATA_WIDTH-1:0]    WMASK      = WMASK_FULL[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0]    RMASK      = RMASK_FULL[DATA_WIDTH-1:0];

  seq_state_t           state_q, state_d;
  logic                 rdy_q;
  logic                 rw_q;
  logic [GAP_WIDTH-1:0] gap_q;
  logic [GAP_WIDTH-1:0] cnt_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] mask_q;
  logic [DATA_BITS-1:0]  rdata_q;

  logic           accept;
  logic           last_wait;
  logic [LEN-1:0] word;
  logic           unused_read_hi;

  assign accept    = bus.cmd_valid && rdy_q;
  assign last_wait = (state_q == WAIT) && (cnt_q == GAP_WIDTH'(1));
  assign word      = {bus.cmd_rw, bus.cmd_addr,
                      (bus.cmd_rw ? {DATA_BITS{1'b0}} : bus.cmd_wdata)};
  assign unused_read_hi = ^transaction_read_data[DATA_WIDTH-1:DATA_BITS];

  always_comb begin
    state_d            = state_q;
    transaction_length = '0;
    busy               = 1'b1;
    bus.rsp_valid      = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (accept) state_d = LAUNCH;
      end
      LAUNCH: begin
        transaction_length = LEN_VAL;
        state_d            = WAIT;
      end
      WAIT: begin
        if (last_wait) state_d = rw_q ? RESP : IDLE;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // cmd_ready is registered so it stays low through the reset edge and rises one cycle later.
  always_ff @(posedge fabric_clk) begin
    if (reset) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      rw_q    <= 1'b0;
      gap_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d == IDLE);
      if (accept) begin
        rw_q   <= bus.cmd_rw;
        gap_q  <= bus.gap_cycles;
        data_q <= DATA_WIDTH'(word);
        mask_q <= bus.cmd_rw ? RMASK : WMASK;
      end
      if (state_q == LAUNCH) begin
        cnt_q <= (gap_q == '0) ? GAP_WIDTH'(1) : gap_q;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - GAP_WIDTH'(1);
      end
      if (last_wait && rw_q) begin
        rdata_q <= transaction_read_data[DATA_BITS-1:0];
      end
    end
  end

  assign bus.cmd_ready       = rdy_q;
  assign bus.rsp_rdata       = rdata_q;
  assign transaction_data    = data_q;
  assign transaction_rw_mask = mask_q;

endmodule

// File: tb/tb_spi_command_sequencer.sv
// Randomized and directed checks of spi_command_sequencer against an arithmetic reference model.
module tb_spi_command_sequencer;

  localparam int DW  = 32;
  localparam int TLW = 8;
  localparam int AW  = 15;
  localparam int DB  = 8;
  localparam int GW  = 16;
  localparam int LEN = 1 + AW + DB;

  logic fabric_clk = 1'b0;
  logic reset      = 1'b1;
  always #5 fabric_clk = ~fabric_clk;

  spi_command_sequencer_if #(.ADDR_WIDTH(AW), .DATA_BITS(DB), .GAP_WIDTH(GW)) bus ();

  logic [TLW-1:0] transaction_length;
  logic [DW-1:0]  transaction_data;
  logic [DW-1:0]  transaction_rw_mask;
  logic [DW-1:0]  transaction_read_data;
  logic           busy;

  spi_command_sequencer #(
    .DATA_WIDTH(DW), .TRANSACTION_LEN_WIDTH(TLW), .ADDR_WIDTH(AW),
    .DATA_BITS(DB), .GAP_WIDTH(GW)
  ) dut (
    .fabric_clk            (fabric_clk),
    .reset                 (reset),
    .bus                   (bus.slave),
    .transaction_length    (transaction_length),
    .transaction_data      (transaction_data),
    .transaction_rw_mask   (transaction_rw_mask),
    .transaction_read_data (transaction_read_data),
    .busy                  (busy)
  );

  int vectors     = 0;
  int miscompares = 0;

  function automatic logic [DW-1:0] model_word(input bit rw, input int addr, input int wdata);
    logic [63:0] w;
    w = (64'(rw) << (AW + DB)) | (64'(addr & 32'h7FFF) << DB) | (rw ? 64'd0 : 64'(wdata & 32'hFF));
    return DW'(w);
  endfunction

  function automatic logic [DW-1:0] model_mask(input bit rw);
    logic [63:0] m;
    m = (64'd1 << LEN) - 64'd1;
    if (rw) m = m & ~((64'd1 << DB) - 64'd1);
    return DW'(m);
  endfunction

  // Stimulus only: presents a command and returns in the LAUNCH cycle with cmd_valid dropped.
  task automatic accept_cmd(input bit rw, input int addr, input int wdata, input int gap,
                            output bit ok);
    @(negedge fabric_clk);
    bus.cmd_rw     = rw;
    bus.cmd_addr   = AW'(addr);
    bus.cmd_wdata  = DB'(wdata);
    bus.gap_cycles = GW'(gap);
    bus.cmd_valid  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge fabric_clk);
    end
    @(negedge fabric_clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && !bus.cmd_ready; i++) @(negedge fabric_clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge fabric_clk);
    vectors++;
    if ({bus.cmd_ready, bus.rsp_valid, busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_ctrl: ready/valid/busy got %b expected 000", {bus.cmd_ready, bus.rsp_valid, busy});
    end
    vectors++;
    if (transaction_length !== '0 || transaction_data !== '0 || transaction_rw_mask !== '0 || bus.rsp_rdata !== '0) begin
      miscompares++;
      $display("FAIL reset_data: len %0h data %0h mask %0h rdata %0h expected all 0",
               transaction_length, transaction_data, transaction_rw_mask, bus.rsp_rdata);
    end
    reset = 1'b0;
    @(negedge fabric_clk);
    vectors++;
    if (bus.cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready_rise: got %b expected 1", bus.cmd_ready);
    end
  endtask

  task automatic test_write();
    bit ok;
    int first_rdy = 0, len_bad = 0, vld_seen = 0;
    accept_cmd(1'b0, 'h0003, 'hA5, 10, ok);
    vectors++;
    if (!ok || transaction_length !== TLW'(24)) begin
      miscompares++;
      $display("FAIL write_len: accepted %b len %0d expected 24", ok, transaction_length);
    end
    vectors++;
    if (transaction_data !== 32'h0003A5 || transaction_rw_mask !== 32'hFFFFFF) begin
      miscompares++;
      $display("FAIL write_word: data %h mask %h expected 000003a5/00ffffff", transaction_data, transaction_rw_mask);
    end
    for (int k = 2; k < 40; k++) begin
      @(negedge fabric_clk);
      if (transaction_length !== '0) len_bad++;
      if (bus.rsp_valid) vld_seen++;
      if (bus.cmd_ready) begin
        first_rdy = k;
        break;
      end
    end
    vectors++;
    if (first_rdy != 12 || len_bad != 0 || vld_seen != 0) begin
      miscompares++;
      $display("FAIL write_timing: ready at %0d (expected 12), extra length cycles %0d, rsp_valid cycles %0d",
               first_rdy, len_bad, vld_seen);
    end
  endtask

  task automatic test_read(input bit hold);
    bit ok;
    int first_vld = 0, bad = 0;
    bus.rsp_ready = !hold;
    transaction_read_data = 32'hDEADBE5C;
    accept_cmd(1'b1, 'h0010, int'($urandom), 5, ok);
    vectors++;
    if (!ok || transaction_data !== 32'h801000 || transaction_rw_mask !== 32'hFFFF00) begin
      miscompares++;
      $display("FAIL read_word: data %h mask %h expected 00801000/00ffff00", transaction_data, transaction_rw_mask);
    end
    for (int k = 2; k < 40; k++) begin
      @(negedge fabric_clk);
      if (bus.rsp_valid) begin
        first_vld = k;
        break;
      end
    end
    vectors++;
    if (first_vld != 7 || bus.rsp_rdata !== 8'h5C) begin
      miscompares++;
      $display("FAIL read_rsp: valid at %0d rdata %h expected 7/5c", first_vld, bus.rsp_rdata);
    end
    transaction_read_data = 32'h000000FF;
    if (hold) begin
      for (int i = 0; i < 20; i++) begin
        @(negedge fabric_clk);
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 8'h5C || bus.cmd_ready !== 1'b0) bad++;
      end
      vectors++;
      if (bad != 0) begin
        miscompares++;
        $display("FAIL read_hold: %0d unstable cycles expected 0", bad);
      end
      bus.rsp_ready = 1'b1;
    end
    @(negedge fabric_clk);
    vectors++;
    if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL read_release: ready %b valid %b expected 1/0", bus.cmd_ready, bus.rsp_valid);
    end
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_gap_zero_back_to_back();
    int acc_cyc[$];
    logic [DW-1:0] exp_q = '0;
    bit pending = 0;
    int len_cnt = 0, addr = 0, wdata = 0;
    @(negedge fabric_clk);
    bus.cmd_rw     = 1'b0;
    bus.gap_cycles = '0;
    bus.cmd_valid  = 1'b1;
    for (int c = 0; c < 40 && acc_cyc.size() < 3; c++) begin
      addr  = int'($urandom);
      wdata = int'($urandom);
      bus.cmd_addr  = AW'(addr);
      bus.cmd_wdata = DB'(wdata);
      if (pending) begin
        vectors++;
        if (transaction_data !== exp_q) begin
          miscompares++;
          $display("FAIL b2b_data: got %h expected %h", transaction_data, exp_q);
        end
        pending = 0;
      end
      if (transaction_length !== '0) len_cnt++;
      if (bus.cmd_ready) begin
        acc_cyc.push_back(c);
        exp_q   = model_word(1'b0, addr, wdata);
        pending = 1;
      end
      @(negedge fabric_clk);
    end
    bus.cmd_valid = 1'b0;
    vectors++;
    if (transaction_data !== exp_q || transaction_length !== TLW'(LEN)) begin
      miscompares++;
      $display("FAIL b2b_last: data %h len %0d expected %h/%0d", transaction_data, transaction_length, exp_q, LEN);
    end
    vectors++;
    if (acc_cyc.size() != 3 || acc_cyc[1] - acc_cyc[0] != 3 || acc_cyc[2] - acc_cyc[1] != 3 || len_cnt != 2) begin
      miscompares++;
      $display("FAIL b2b_spacing: %0d accepts, spacing %0d/%0d, launches %0d expected 3 accepts 3/3 and 2",
               acc_cyc.size(), acc_cyc.size() > 1 ? acc_cyc[1] - acc_cyc[0] : -1,
               acc_cyc.size() > 2 ? acc_cyc[2] - acc_cyc[1] : -1, len_cnt);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    int vld_seen = 0, first_rdy = 0;
    transaction_read_data = 32'h12345699;
    bus.rsp_ready = 1'b1;
    accept_cmd(1'b1, 'h2AAA, 0, 20, ok);
    repeat (5) @(negedge fabric_clk);
    reset = 1'b1;
    @(negedge fabric_clk);
    vectors++;
    if ({bus.cmd_ready, bus.rsp_valid, busy} !== 3'b000 || transaction_length !== '0 ||
        transaction_data !== '0 || transaction_rw_mask !== '0 || bus.rsp_rdata !== '0) begin
      miscompares++;
      $display("FAIL midwait_reset: rdy/vld/busy %b len %0d data %h mask %h rdata %h expected all 0",
               {bus.cmd_ready, bus.rsp_valid, busy}, transaction_length, transaction_data,
               transaction_rw_mask, bus.rsp_rdata);
    end
    @(negedge fabric_clk);
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge fabric_clk);
      if (bus.rsp_valid) vld_seen++;
    end
    vectors++;
    if (vld_seen != 0) begin
      miscompares++;
      $display("FAIL midwait_no_rsp: rsp_valid cycles %0d expected 0", vld_seen);
    end
    bus.rsp_ready = 1'b0;
    accept_cmd(1'b0, 'h0155, 'h3C, 3, ok);
    for (int k = 2; k < 30; k++) begin
      @(negedge fabric_clk);
      if (bus.cmd_ready) begin
        first_rdy = k;
        break;
      end
    end
    vectors++;
    if (!ok || transaction_data !== model_word(1'b0, 'h0155, 'h3C) || first_rdy != 5) begin
      miscompares++;
      $display("FAIL midwait_recover: data %h ready at %0d expected %h/5",
               transaction_data, first_rdy, model_word(1'b0, 'h0155, 'h3C));
    end
  endtask

  task automatic test_addr_change();
    bit ok;
    int bad = 0;
    logic [DW-1:0] exp_w;
    exp_w = model_word(1'b0, 'h1234, 'h77);
    accept_cmd(1'b0, 'h1234, 'h77, 4, ok);
    bus.cmd_addr   = AW'('h7FFF);
    bus.cmd_wdata  = 8'h11;
    bus.cmd_rw     = 1'b1;
    bus.gap_cycles = GW'(50);
    for (int k = 1; k < 12; k++) begin
      if (transaction_data !== exp_w || transaction_rw_mask !== model_mask(1'b0)) bad++;
      @(negedge fabric_clk);
    end
    vectors++;
    if (!ok || bad != 0 || bus.cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL addr_change: %0d cycles differ from %h, ready %b expected 0 and 1", bad, exp_w, bus.cmd_ready);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      bit ok, rw;
      int addr, wdata, gap, delay, g, first_vld, first_rdy, ack_k, len_bad, rd_bad;
      logic [DW-1:0] rdat;
      logic [DB-1:0] exp_rd;
      rw    = 1'($urandom_range(0, 1));
      addr  = int'($urandom);
      wdata = int'($urandom);
      gap   = int'($urandom_range(0, 8));
      delay = int'($urandom_range(0, 3));
      rdat  = $urandom;
      exp_rd = rdat[DB-1:0];
      g = (gap == 0) ? 1 : gap;
      first_vld = 0; first_rdy = 0; ack_k = 0; len_bad = 0; rd_bad = 0;
      transaction_read_data = rdat;
      bus.rsp_ready = (delay == 0);
      accept_cmd(rw, addr, wdata, gap, ok);
      vectors++;
      if (!ok || transaction_length !== TLW'(LEN) || transaction_data !== model_word(rw, addr, wdata) ||
          transaction_rw_mask !== model_mask(rw)) begin
        miscompares++;
        $display("FAIL rand_launch[%0d]: len %0d data %h mask %h expected %0d/%h/%h", n, transaction_length,
                 transaction_data, transaction_rw_mask, LEN, model_word(rw, addr, wdata), model_mask(rw));
      end
      for (int k = 2; k < 200; k++) begin
        @(negedge fabric_clk);
        if (transaction_length !== '0) len_bad++;
        if (bus.rsp_valid && first_vld == 0) first_vld = k;
        if (bus.rsp_valid && bus.rsp_rdata !== exp_rd) rd_bad++;
        if (first_vld != 0 && k >= first_vld + delay) bus.rsp_ready = 1'b1;
        if (bus.rsp_valid && bus.rsp_ready && ack_k == 0) ack_k = k;
        if (bus.cmd_ready) begin
          first_rdy = k;
          break;
        end
        if (k >= 2 + g) transaction_read_data = $urandom;
      end
      bus.rsp_ready = 1'b0;
      vectors++;
      if (first_vld != (rw ? 2 + g : 0) || first_rdy != (rw ? 3 + g + delay : 2 + g) ||
          len_bad != 0 || rd_bad != 0) begin
        miscompares++;
        $display("FAIL rand_timing[%0d]: rw %0d gap %0d vld %0d rdy %0d expected %0d/%0d, len_bad %0d rd_bad %0d",
                 n, rw, gap, first_vld, first_rdy, rw ? 2 + g : 0, rw ? 3 + g + delay : 2 + g, len_bad, rd_bad);
      end
    end
  endtask

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_rw     = 1'b0;
    bus.cmd_addr   = '0;
    bus.cmd_wdata  = '0;
    bus.gap_cycles = '0;
    bus.rsp_ready  = 1'b0;
    transaction_read_data = '0;
    test_reset();
    test_write();
    test_read(1'b0);
    test_read(1'b1);
    test_gap_zero_back_to_back();
    test_reset_mid_wait();
    test_addr_change();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_command_sequencer.md
# spi_command_sequencer

Register-access front end for `bidirectional_spi`, sitting directly upstream of it in the `fabric_clk` domain. It accepts one register read/write command at a time over a valid/ready handshake and formats it as an instruction word: R/W bit, then address, then data. It launches that word as a single-cycle transaction request to the SPI core. It waits a programmable guard interval, because the SPI core has no completion flag, and for reads returns the captured data over a valid/ready response channel.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of the SPI core data/mask buses.
- `TRANSACTION_LEN_WIDTH`, 8: width of the SPI core length field.
- `ADDR_WIDTH`, 15: register address bits.
- `DATA_BITS`, 8: register data bits.
- `GAP_WIDTH`, 16: width of the guard-interval counter.

Derived:
- `LEN = 1 + ADDR_WIDTH + DATA_BITS` (24 at defaults).
- Elaboration error if `LEN > DATA_WIDTH` or `LEN >= 2**TRANSACTION_LEN_WIDTH`.

Ports:
- `fabric_clk` in 1: single clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when high together with `cmd_valid`.
- `cmd_rw` in 1: 1 = read, 0 = write.
- `cmd_addr` in ADDR_WIDTH: register address.
- `cmd_wdata` in DATA_BITS: write data; ignored for reads.
- `gap_cycles` in GAP_WIDTH: guard interval in `fabric_clk` cycles; sampled at accept.
- `transaction_length` out TRANSACTION_LEN_WIDTH: SPI core length request.
- `transaction_data` out DATA_WIDTH: SPI core shift data.
- `transaction_rw_mask` out DATA_WIDTH: SPI core direction mask (1 = drive).
- `transaction_read_data` in DATA_WIDTH: read data from the SPI core.
- `rsp_valid` out 1: read response present.
- `rsp_ready` in 1: response consumed when high together with `rsp_valid`.
- `rsp_rdata` out DATA_BITS: read data.
- `busy` out 1: high in every state except IDLE.

## Operation
- States:
  - IDLE: `cmd_ready`=1. On accept, latch `cmd_rw`, `cmd_addr`, `cmd_wdata` and `gap_cycles` → LAUNCH.
  - LAUNCH: `transaction_length`=LEN for exactly this one cycle; counter loaded with max(`gap_cycles`, 1) → WAIT.
  - WAIT: counter decrements by 1 each cycle. On the cycle the counter is 1:
    - read: capture `transaction_read_data[DATA_BITS-1:0]` into `rsp_rdata`, assert `rsp_valid` → RESP.
    - write: → IDLE.
  - RESP: hold `rsp_valid` and `rsp_rdata` until `rsp_ready`, then → IDLE. Writes generate no response.
- Word formatting, right-aligned; bit LEN-1 is shifted first:
  - `transaction_data = {cmd_rw, cmd_addr, (cmd_rw ? 0 : cmd_wdata)}`, zero-extended to DATA_WIDTH.
  - Mask for a write: ones in bits [LEN-1:0].
  - Mask for a read: ones in bits [LEN-1:DATA_BITS], zeros in bits [DATA_BITS-1:0].
  - Bits at and above LEN are always 0.
- `transaction_length` is 0 in every state except LAUNCH. A length held nonzero would make the SPI core relaunch, so this is mandatory.
- `transaction_data` and `transaction_rw_mask` are registered at accept and held stable until the next accept.
- Guard sizing is the software's responsibility. `gap_cycles` must cover both clock-domain FIFO crossings plus LEN SPI bit times plus chip-select overhead.

## Timing
- Reset values: `cmd_ready`=0, `rsp_valid`=0, `busy`=0, `transaction_length`=0, `transaction_data`=0, `transaction_rw_mask`=0, `rsp_rdata`=0, state=IDLE.
- `cmd_ready` rises the first cycle after `reset` deasserts.
- Accept at edge T: LAUNCH during cycle T+1; WAIT covers cycles T+2 … T+1+G, where G = max(gap,1).
- Read: `rsp_valid` high from cycle T+2+G.
- Write: `cmd_ready` high again at cycle T+2+G.
- Back-to-back writes with `cmd_valid` held: one accept every G+2 cycles.
- `rsp_ready` may be held high before `rsp_valid`; the handshake then completes in the first cycle of RESP, and the block returns to IDLE the following cycle.
- Changes on `cmd_*` or `gap_cycles` outside the accept cycle have no effect.
- Reset asserted in any state, including LAUNCH or mid-WAIT: next edge goes to IDLE with all outputs at reset values. A pending response is discarded.

## Structure
- Package `spi_seq_pkg`:
  - state enum `seq_state_t` (IDLE, LAUNCH, WAIT, RESP);
  - function `seq_len(addr_w, data_w)` returning LEN;
  - function `seq_mask(len, data_w, rw)` returning DATA_WIDTH mask.
- Single flat module; no sub-module is natural. The gap counter and formatting are too small to split out.

## Test plan
- Write `addr=0x0003`, `wdata=0xA5`, `gap=10`:
  - `transaction_data=0x0003A5`, `mask=0xFFFFFF`;
  - `length=24` for exactly one cycle;
  - `cmd_ready` back 12 cycles after accept; no `rsp_valid`.
- Read `addr=0x0010`, `gap=5`, `transaction_read_data=0x5C` driven:
  - `transaction_data=0x801000`, `mask=0xFFFF00`;
  - `rsp_valid` 7 cycles after accept with `rsp_rdata=0x5C`.
- Same read with `rsp_ready` held low for 20 cycles:
  - `rsp_valid` and `rsp_rdata` stable throughout;
  - `cmd_ready`=0 until the handshake, then 1 the next cycle.
- `gap=0`, two back-to-back writes with `cmd_valid` held: behaves as `gap=1`; accepts exactly 3 cycles apart.
- `reset` pulsed mid-WAIT of a read: no `rsp_valid`; all outputs return to reset values; the next command runs normally.
- `cmd_addr` changed the cycle after accept: `transaction_data` unchanged.
